// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the fetch queue and its lane compactor.
package fetch_pkg;

    localparam int          FETCH_XLEN   = 32;
    localparam logic [31:0] FETCH_PC_END = 32'h250;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [7:0] popcount(input logic [31:0] m);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + 8'(m[i]);
        return c;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-source / decode-side bundle of the fetch queue. FETCHQ_PERF_EN adds perf counters.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int XLEN    = FETCH_XLEN,
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
);
    logic                              stall_if;
    logic                              flush_if;
    logic [FETCH_W-1:0]                in_valid;
    logic [FETCH_W-1:0][XLEN-1:0]      in_instr;
    logic [FETCH_W-1:0][XLEN-1:0]      in_pc;
    logic                              in_ready;
    logic [ISSUE_W-1:0]                out_valid;
    logic [ISSUE_W-1:0][XLEN-1:0]      out_instr;
    logic [ISSUE_W-1:0][XLEN-1:0]      out_pc;
    logic [$clog2(DEPTH):0]            count;
`ifdef FETCHQ_PERF_EN
    logic [31:0]                       full_cycles;
    logic [31:0]                       pc_drops;
`endif

    modport master (
        output stall_if, flush_if, in_valid, in_instr, in_pc,
        input  in_ready, out_valid, out_instr, out_pc, count
`ifdef FETCHQ_PERF_EN
        , input full_cycles, pc_drops
`endif
    );

    modport slave (
        input  stall_if, flush_if, in_valid, in_instr, in_pc,
        output in_ready, out_valid, out_instr, out_pc, count
`ifdef FETCHQ_PERF_EN
        , output full_cycles, pc_drops
`endif
    );

endinterface

// File: rtl/fetch_lane_compact.sv
// Filters fetch lanes against PC_END and packs survivors into consecutive slots, lane order kept.
module fetch_lane_compact
    import fetch_pkg::*;
#(
    parameter int                    FETCH_W = 2,
    parameter logic [FETCH_XLEN-1:0] PC_END  = FETCH_PC_END,
    localparam int                   NW      = $clog2(FETCH_W + 1)
) (
    input  logic [FETCH_W-1:0]                  valid,
    input  logic [FETCH_W-1:0][FETCH_XLEN-1:0]  instr,
    input  logic [FETCH_W-1:0][FETCH_XLEN-1:0]  pc,
    output fetch_entry_t [FETCH_W-1:0]          ents,
    output logic [NW-1:0]                       n_push,
    output logic [NW-1:0]                       n_drop
);

    logic [FETCH_W-1:0]         acc;
    logic [FETCH_W-1:0]         drop;
    logic [FETCH_W-1:0][NW-1:0] pre;

    always_comb begin
        acc  = '0;
        drop = '0;
        pre  = '0;
        ents = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            acc[i]  = valid[i] && (pc[i] <= PC_END);
            drop[i] = valid[i] && (pc[i] > PC_END);
        end
        // Destination slot of lane i = number of accepted lanes below it.
        for (int i = 0; i < FETCH_W; i++)
            pre[i] = NW'(popcount(32'(acc) & ((32'd1 << i) - 32'd1)));
        for (int j = 0; j < FETCH_W; j++) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (acc[i] && pre[i] == NW'(j)) begin
                    ents[j].instr = instr[i];
                    ents[j].pc    = pc[i];
                end
            end
        end
        n_push = NW'(popcount(32'(acc)));
        n_drop = NW'(popcount(32'(drop)));
    end

endmodule

// File: rtl/fetch_queue.sv
// In-order circular fetch buffer: FETCH_W lanes in, oldest ISSUE_W out. FETCHQ_PERF_EN adds
// saturating full_cycles / pc_drops counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN    = FETCH_XLEN,
    parameter int              DEPTH   = 8,
    parameter int              FETCH_W = 2,
    parameter int              ISSUE_W = 2,
    parameter logic [XLEN-1:0] PC_END  = FETCH_PC_END
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(FETCH_W + 1);

    fetch_entry_t [FETCH_W-1:0] ents;
    logic [NW-1:0]              n_push;
    logic [NW-1:0]              n_drop;

    fetch_lane_compact #(.FETCH_W(FETCH_W), .PC_END(PC_END)) u_compact (
        .valid  (bus.in_valid),
        .instr  (bus.in_instr),
        .pc     (bus.in_pc),
        .ents   (ents),
        .n_push (n_push),
        .n_drop (n_drop)
    );

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   push_n, pop_n;
    logic            in_ready, do_push, do_pop;

    // Credit check uses registered occupancy only; same-cycle pops are not counted.
    assign in_ready = count_q <= CW'(DEPTH - FETCH_W);
    assign do_push  = in_ready && !bus.flush_if;
    assign do_pop   = !bus.stall_if && !bus.flush_if;

    always_comb begin
        push_n = do_push ? CW'(n_push) : '0;
        pop_n  = '0;
        if (do_pop) pop_n = (count_q >= CW'(ISSUE_W)) ? CW'(ISSUE_W) : count_q;
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush_if) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int j = 0; j < FETCH_W; j++)
                if (do_push && NW'(j) < n_push) mem_d[tail_q + PW'(j)] = ents[j];
            tail_d  = tail_q + PW'(push_n);
            head_d  = head_q + PW'(pop_n);
            count_d = count_q + push_n - pop_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) mem_q <= mem_d;

    always_comb begin
        bus.out_valid = '0;
        bus.out_instr = '0;
        bus.out_pc    = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (count_q > CW'(i)) begin
                bus.out_valid[i] = 1'b1;
                bus.out_instr[i] = mem_q[head_q + PW'(i)].instr;
                bus.out_pc[i]    = mem_q[head_q + PW'(i)].pc;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.count    = count_q;

`ifdef FETCHQ_PERF_EN
    logic [31:0] full_cycles_q, full_cycles_d;
    logic [31:0] pc_drops_q, pc_drops_d;
    logic [32:0] drop_sum;

    always_comb begin
        full_cycles_d = full_cycles_q;
        if (count_q == CW'(DEPTH) && full_cycles_q != '1) full_cycles_d = full_cycles_q + 32'd1;
        drop_sum   = {1'b0, pc_drops_q} + (do_push ? 33'(n_drop) : 33'd0);
        pc_drops_d = drop_sum[32] ? '1 : drop_sum[31:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_cycles_q <= '0;
            pc_drops_q    <= '0;
        end else begin
            full_cycles_q <= full_cycles_d;
            pc_drops_q    <= pc_drops_d;
        end
    end

    assign bus.full_cycles = full_cycles_q;
    assign bus.pc_drops    = pc_drops_q;
`else
    wire unused_drop = ^n_drop;
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table plus hand sequences for reset, wrap, flush, 3-lane drop.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32), .DEPTH(8), .FETCH_W(2), .ISSUE_W(2)) bus_a ();
    fetch_queue_if #(.XLEN(32), .DEPTH(8), .FETCH_W(3), .ISSUE_W(2)) bus_b ();

    fetch_queue #(.XLEN(32), .DEPTH(8), .FETCH_W(2), .ISSUE_W(2), .PC_END(32'h250)) u_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
    fetch_queue #(.XLEN(32), .DEPTH(8), .FETCH_W(3), .ISSUE_W(2), .PC_END(32'h250)) u_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave));

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [1:0]  vld;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [1:0]  ev;
        int          ec;
        logic        er;
        logic [31:0] epc0;
        logic [31:0] epc1;
    } vec_t;

    vec_t tv [16];

    function automatic logic [31:0] ins(input logic [31:0] p);
        if (p == 32'h0) return 32'h0000_0013;
        if (p == 32'h4) return 32'h0010_0093;
        return 32'hDEAD_0000 | p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic st, input logic fl, input logic [1:0] v,
                         input logic [31:0] p0, input logic [31:0] p1);
        bus_a.stall_if    = st;
        bus_a.flush_if    = fl;
        bus_a.in_valid    = v;
        bus_a.in_pc[0]    = p0;
        bus_a.in_pc[1]    = p1;
        bus_a.in_instr[0] = ins(p0);
        bus_a.in_instr[1] = ins(p1);
    endtask

    task automatic drv_b(input logic st, input logic [2:0] v,
                         input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
        bus_b.stall_if    = st;
        bus_b.flush_if    = 1'b0;
        bus_b.in_valid    = v;
        bus_b.in_pc[0]    = p0;
        bus_b.in_pc[1]    = p1;
        bus_b.in_pc[2]    = p2;
        bus_b.in_instr[0] = ins(p0);
        bus_b.in_instr[1] = ins(p1);
        bus_b.in_instr[2] = ins(p2);
    endtask

    initial begin
        int cnt_m;
        int npop;
        logic rdy_m;
        logic [31:0] head_pc, push_pc;

        drv_a(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drv_b(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);

        // reset state while reset_n is held low
        #3;
        chk("rst_count", 32'(bus_a.count), 32'd0);
        chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_ready", 32'(bus_a.in_ready), 32'd1);
        chk("rst_pc0", bus_a.out_pc[0], 32'd0);
        chk("rst_instr0", bus_a.out_instr[0], 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        chk("idle_count", 32'(bus_a.count), 32'd0);
        chk("idle_valid", 32'(bus_a.out_valid), 32'd0);

        //            stall flush vld    p0         p1         ev     ec er epc0       epc1
        tv[0]  = '{1'b1, 1'b0, 2'b11, 32'h0,     32'h4,     2'b11, 2, 1'b1, 32'h0,   32'h4};
        tv[1]  = '{1'b1, 1'b0, 2'b11, 32'h0,     32'h4,     2'b11, 4, 1'b1, 32'h0,   32'h4};
        tv[2]  = '{1'b1, 1'b0, 2'b11, 32'h0,     32'h4,     2'b11, 6, 1'b1, 32'h0,   32'h4};
        tv[3]  = '{1'b1, 1'b0, 2'b11, 32'h0,     32'h4,     2'b11, 8, 1'b0, 32'h0,   32'h4};
        tv[4]  = '{1'b1, 1'b0, 2'b11, 32'h0,     32'h4,     2'b11, 8, 1'b0, 32'h0,   32'h4};
        tv[5]  = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b11, 6, 1'b1, 32'h0,   32'h4};
        tv[6]  = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b11, 4, 1'b1, 32'h0,   32'h4};
        tv[7]  = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b11, 2, 1'b1, 32'h0,   32'h4};
        tv[8]  = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b00, 0, 1'b1, 32'h0,   32'h0};
        tv[9]  = '{1'b0, 1'b0, 2'b10, 32'h0,     32'h8,     2'b01, 1, 1'b1, 32'h8,   32'h0};
        tv[10] = '{1'b0, 1'b0, 2'b11, 32'h300,   32'h10,    2'b01, 1, 1'b1, 32'h10,  32'h0};
        tv[11] = '{1'b0, 1'b0, 2'b11, 32'h250,   32'h251,   2'b01, 1, 1'b1, 32'h250, 32'h0};
        tv[12] = '{1'b1, 1'b0, 2'b11, 32'h14,    32'h18,    2'b11, 3, 1'b1, 32'h250, 32'h14};
        tv[13] = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b01, 1, 1'b1, 32'h18,  32'h0};
        tv[14] = '{1'b0, 1'b1, 2'b11, 32'h20,    32'h24,    2'b00, 0, 1'b1, 32'h0,   32'h0};
        tv[15] = '{1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b00, 0, 1'b1, 32'h0,   32'h0};

        for (int k = 0; k < 16; k++) begin
            drv_a(tv[k].stall, tv[k].flush, tv[k].vld, tv[k].p0, tv[k].p1);
            tick();
            chk($sformatf("v%0d_count", k), 32'(bus_a.count), 32'(tv[k].ec));
            chk($sformatf("v%0d_ready", k), 32'(bus_a.in_ready), 32'(tv[k].er));
            chk($sformatf("v%0d_valid", k), 32'(bus_a.out_valid), 32'(tv[k].ev));
            chk($sformatf("v%0d_pc0", k), bus_a.out_pc[0], tv[k].epc0);
            chk($sformatf("v%0d_pc1", k), bus_a.out_pc[1], tv[k].epc1);
            chk($sformatf("v%0d_instr0", k), bus_a.out_instr[0],
                tv[k].ev[0] ? ins(tv[k].epc0) : 32'h0);
        end
`ifdef FETCHQ_PERF_EN
        chk("perf_full_tbl", bus_a.full_cycles, 32'd2);
        chk("perf_drops_tbl", bus_a.pc_drops, 32'd2);
`endif

        // fill to an odd count, then async reset mid-cycle
        drv_a(1'b1, 1'b0, 2'b11, 32'h40, 32'h44); tick();
        drv_a(1'b1, 1'b0, 2'b11, 32'h48, 32'h4C); tick();
        drv_a(1'b1, 1'b0, 2'b01, 32'h50, 32'h0);  tick();
        chk("pre_rst_count", 32'(bus_a.count), 32'd5);
        drv_a(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(bus_a.count), 32'd0);
        chk("async_rst_valid", 32'(bus_a.out_valid), 32'd0);
        chk("async_rst_ready", 32'(bus_a.in_ready), 32'd1);
        reset_n = 1'b1;

        // fill, then stream with tail wrapping; model tracks head pc and occupancy
        cnt_m = 0; head_pc = 32'h100; push_pc = 32'h100;
        for (int k = 0; k < 4; k++) begin
            drv_a(1'b1, 1'b0, 2'b11, push_pc, push_pc + 32'd4);
            tick();
            push_pc += 32'd8;
            cnt_m += 2;
        end
        chk("wrap_full_count", 32'(bus_a.count), 32'd8);
        chk("wrap_full_ready", 32'(bus_a.in_ready), 32'd0);
        for (int c = 0; c < 10; c++) begin
            rdy_m = (8 - cnt_m) >= 2;
            npop  = (cnt_m < 2) ? cnt_m : 2;
            drv_a(1'b0, 1'b0, 2'b11, push_pc, push_pc + 32'd4);
            tick();
            if (rdy_m) begin
                push_pc += 32'd8;
                cnt_m += 2;
            end
            cnt_m   -= npop;
            head_pc += 32'(4 * npop);
            chk($sformatf("wrap%0d_count", c), 32'(bus_a.count), 32'(cnt_m));
            chk($sformatf("wrap%0d_pc0", c), bus_a.out_pc[0], head_pc);
            chk($sformatf("wrap%0d_pc1", c), bus_a.out_pc[1], head_pc + 32'd4);
        end

        // flush at count 6 with a simultaneous push
        chk("pre_flush_count", 32'(bus_a.count), 32'd6);
        drv_a(1'b0, 1'b1, 2'b11, push_pc, push_pc + 32'd4);
        tick();
        chk("flush_count", 32'(bus_a.count), 32'd0);
        chk("flush_valid", 32'(bus_a.out_valid), 32'd0);
        drv_a(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        chk("post_flush_count", 32'(bus_a.count), 32'd0);
        chk("post_flush_valid", 32'(bus_a.out_valid), 32'd0);
`ifdef FETCHQ_PERF_EN
        chk("perf_full_wrap", bus_a.full_cycles, 32'd1);
`endif

        // three-lane build: pc above PC_END dropped, PC_END itself kept
        drv_b(1'b1, 3'b111, 32'h24C, 32'h250, 32'h254);
        tick();
        chk("b_count1", 32'(bus_b.count), 32'd2);
        chk("b_valid1", 32'(bus_b.out_valid), 32'd3);
        chk("b_pc0", bus_b.out_pc[0], 32'h24C);
        chk("b_pc1", bus_b.out_pc[1], 32'h250);
        drv_b(1'b1, 3'b011, 32'h260, 32'h30, 32'h0);
        tick();
        chk("b_count2", 32'(bus_b.count), 32'd3);
        chk("b_pc0_hold", bus_b.out_pc[0], 32'h24C);
        drv_b(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();
        chk("b_count3", 32'(bus_b.count), 32'd1);
        chk("b_pc0_comp", bus_b.out_pc[0], 32'h30);
        chk("b_instr0_comp", bus_b.out_instr[0], ins(32'h30));
        chk("b_valid3", 32'(bus_b.out_valid), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
